rs_param_station: RTL and testbench

Parametrised reservation station for the Tomasulo out-of-order core. It replaces the fixed four-slot add/multiply station with a DEPTH-entry buffer and uses an explicit handshake on both sides. Allocation comes from a free-list: the lowest free entry is taken and its tag is returned to the RAT. Waiting operands snoop the common data bus (CDB), with a same-cycle bypass at dispatch. Issue to the functional unit is oldest-ready-first through a registered output stage, and a flush input clears the station.

---
 rtl/rs_param_station.sv | 181 ++++++++++++++++++
 tb/tb_rs_param_station.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_param_station.sv
// Parametrised reservation station: free-list allocation, CDB wakeup with dispatch bypass,
// age-matrix oldest-ready selection into a registered issue stage, synchronous flush.
module rs_param_station #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 3,
    parameter int RS_BASE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    output logic [TAG_W-1:0]           disp_tag,
    input  logic [OP_W-1:0]            disp_op,
    input  logic                       disp_src1_rdy,
    input  logic [XLEN-1:0]            disp_src1_val,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic                       disp_src2_rdy,
    input  logic [XLEN-1:0]            disp_src2_val,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_value,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [OP_W-1:0]            issue_op,
    output logic [XLEN-1:0]            issue_src1,
    output logic [XLEN-1:0]            issue_src2,
    output logic [TAG_W-1:0]           issue_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_rdy1;
    logic [DEPTH-1:0] r_rdy2;
    logic [OP_W-1:0]  r_op   [DEPTH];
    logic [XLEN-1:0]  r_val1 [DEPTH];
    logic [XLEN-1:0]  r_val2 [DEPTH];
    logic [TAG_W-1:0] r_tag1 [DEPTH];
    logic [TAG_W-1:0] r_tag2 [DEPTH];
    logic [DEPTH-1:0] r_age  [DEPTH];

    logic             r_issue_valid;
    logic [OP_W-1:0]  r_issue_op;
    logic [XLEN-1:0]  r_issue_src1;
    logic [XLEN-1:0]  r_issue_src2;
    logic [TAG_W-1:0] r_issue_tag;
    logic [OCC_W-1:0] r_occ;

    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_sel_idx;
    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_sel;
    logic [DEPTH-1:0] w_new;
    logic             w_dispatch;
    logic             w_load;
    logic             w_byp1;
    logic             w_byp2;

    assign disp_ready = (~&r_busy) & ~flush;
    assign disp_tag   = TAG_W'(RS_BASE) + TAG_W'(w_free_idx);
    assign w_dispatch = disp_valid & disp_ready;
    assign w_elig     = r_busy & r_rdy1 & r_rdy2;
    assign w_load     = (|w_elig) & (~r_issue_valid | issue_ready) & ~flush;
    assign w_byp1     = ~disp_src1_rdy & cdb_valid & (cdb_tag == disp_src1_tag);
    assign w_byp2     = ~disp_src2_rdy & cdb_valid & (cdb_tag == disp_src2_tag);

    // Lowest free index, and the one-hot entry receiving this cycle's dispatch.
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            w_free_idx = r_busy[i] ? w_free_idx : IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_new[i] = w_dispatch & (w_free_idx == IDX_W'(i));
        end
    end

    // An eligible entry wins only if it is older than every other eligible entry.
    always_comb begin
        w_sel     = w_elig;
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_sel[i] = w_sel[i] & ((i == j) | ~w_elig[j] | r_age[i][j]);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_sel_idx = w_sel[i] ? IDX_W'(i) : w_sel_idx;
        end
    end

    // Entry array: allocation with bypass, CDB wakeup, free on load, age tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= '0;
                r_val1[i] <= '0;
                r_val2[i] <= '0;
                r_tag1[i] <= '0;
                r_tag2[i] <= '0;
                r_age[i]  <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_new[i]) begin
                    r_busy[i] <= 1'b1;
                    r_op[i]   <= disp_op;
                    r_rdy1[i] <= disp_src1_rdy | w_byp1;
                    r_val1[i] <= w_byp1 ? cdb_value : disp_src1_val;
                    r_tag1[i] <= disp_src1_tag;
                    r_rdy2[i] <= disp_src2_rdy | w_byp2;
                    r_val2[i] <= w_byp2 ? cdb_value : disp_src2_val;
                    r_tag2[i] <= disp_src2_tag;
                end else begin
                    if (w_load && w_sel[i]) begin
                        r_busy[i] <= 1'b0;
                    end
                    if (r_busy[i] && !r_rdy1[i] && cdb_valid && (r_tag1[i] == cdb_tag)) begin
                        r_rdy1[i] <= 1'b1;
                        r_val1[i] <= cdb_value;
                    end
                    if (r_busy[i] && !r_rdy2[i] && cdb_valid && (r_tag2[i] == cdb_tag)) begin
                        r_rdy2[i] <= 1'b1;
                        r_val2[i] <= cdb_value;
                    end
                end
                // A new entry is younger than every entry that is busy right now.
                for (int j = 0; j < DEPTH; j++) begin
                    r_age[i][j] <= w_new[i] ? 1'b0 : (w_new[j] ? r_busy[i] : r_age[i][j]);
                end
            end
        end
    end

    // Issue register and occupancy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_src1  <= '0;
            r_issue_src2  <= '0;
            r_issue_tag   <= '0;
            r_occ         <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
            r_occ         <= '0;
        end else begin
            if (w_load) begin
                r_issue_valid <= 1'b1;
                r_issue_op    <= r_op[w_sel_idx];
                r_issue_src1  <= r_val1[w_sel_idx];
                r_issue_src2  <= r_val2[w_sel_idx];
                r_issue_tag   <= TAG_W'(RS_BASE) + TAG_W'(w_sel_idx);
            end else if (issue_ready) begin
                r_issue_valid <= 1'b0;
            end
            r_occ <= r_occ + OCC_W'(w_dispatch) - OCC_W'(w_load);
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_op    = r_issue_op;
    assign issue_src1  = r_issue_src1;
    assign issue_src2  = r_issue_src2;
    assign issue_tag   = r_issue_tag;
    assign occupancy   = r_occ;

endmodule

// File: tb/tb_rs_param_station.sv
// Directed self-checking bench for rs_param_station (DEPTH=4, RS_BASE=0).
module tb_rs_param_station;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_tag;
    logic [2:0]  disp_op;
    logic        disp_src1_rdy;
    logic [31:0] disp_src1_val;
    logic [3:0]  disp_src1_tag;
    logic        disp_src2_rdy;
    logic [31:0] disp_src2_val;
    logic [3:0]  disp_src2_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [3:0]  issue_tag;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;

    rs_param_station dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .disp_op(disp_op),
        .disp_src1_rdy(disp_src1_rdy), .disp_src1_val(disp_src1_val), .disp_src1_tag(disp_src1_tag),
        .disp_src2_rdy(disp_src2_rdy), .disp_src2_val(disp_src2_val), .disp_src2_tag(disp_src2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_tag(issue_tag),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic dispatch(input logic [2:0] op,
                            input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src1_tag = t1;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
        disp_src2_tag = t2;
        @(negedge clk);
        disp_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] value);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = value;
        @(negedge clk);
        cdb_valid = 1'b0;
    endtask

    // Wake one waiting entry, watch it load, then refill the freed slot with an op waiting on tag 15.
    task automatic wake_refill(input logic [3:0] wtag, input int exp_tag);
        broadcast(wtag, 32'h0000_1000);
        @(negedge clk);
        chk("refill_issue_valid", 64'(issue_valid), 64'h1);
        chk("refill_issue_tag", 64'(issue_tag), 64'(exp_tag));
        chk("refill_issue_src2", 64'(issue_src2), 64'(exp_tag));
        chk("refill_disp_tag", 64'(disp_tag), 64'(exp_tag));
        dispatch(3'(exp_tag), 1'b0, 32'h0, 4'd15, 1'b1, 32'h20 + 32'(exp_tag), 4'd0);
        chk("refill_occ", 64'(occupancy), 64'd4);
    endtask

    initial begin
        int ord [4];
        ord = '{2, 0, 3, 1};
        reset = 1'b0; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
        disp_op = 3'd0; disp_src1_rdy = 1'b0; disp_src1_val = 32'h0; disp_src1_tag = 4'd0;
        disp_src2_rdy = 1'b0; disp_src2_val = 32'h0; disp_src2_tag = 4'd0;
        cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_disp_ready", 64'(disp_ready), 64'h1);
        chk("rst_disp_tag", 64'(disp_tag), 64'd0);
        chk("rst_issue_valid", 64'(issue_valid), 64'h0);
        chk("rst_issue_op", 64'(issue_op), 64'h0);
        chk("rst_issue_src1", 64'(issue_src1), 64'h0);
        chk("rst_issue_src2", 64'(issue_src2), 64'h0);
        chk("rst_issue_tag", 64'(issue_tag), 64'h0);

        // Fill all four entries (waiting on tag 15), then drain in tag order.
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("fill_disp_ready", 64'(disp_ready), 64'h1);
            chk("fill_disp_tag", 64'(disp_tag), 64'(k));
            dispatch(3'(k), 1'b0, 32'h0, 4'd15, 1'b1, 32'(k), 4'd0);
            chk("fill_occ", 64'(occupancy), 64'(k + 1));
        end
        chk("full_disp_ready", 64'(disp_ready), 64'h0);
        broadcast(4'd15, 32'h0000_0100);
        chk("fill_wake_no_issue", 64'(issue_valid), 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_valid", 64'(issue_valid), 64'h1);
            chk("drain_tag", 64'(issue_tag), 64'(k));
            chk("drain_op", 64'(issue_op), 64'(k));
            chk("drain_src1", 64'(issue_src1), 64'h100);
            chk("drain_src2", 64'(issue_src2), 64'(k));
            chk("drain_occ", 64'(occupancy), 64'(3 - k));
        end
        @(negedge clk);
        chk("drain_end_valid", 64'(issue_valid), 64'h0);

        // A waits on tag 9, B is ready: B issues first, A after the broadcast.
        dispatch(3'd1, 1'b0, 32'h0, 4'd9, 1'b1, 32'h2, 4'd0);
        chk("ab_disp_tag_b", 64'(disp_tag), 64'd1);
        dispatch(3'd2, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0);
        chk("ab_not_yet", 64'(issue_valid), 64'h0);
        chk("ab_occ2", 64'(occupancy), 64'd2);
        @(negedge clk);
        chk("ab_b_valid", 64'(issue_valid), 64'h1);
        chk("ab_b_tag", 64'(issue_tag), 64'd1);
        chk("ab_b_src1", 64'(issue_src1), 64'h11);
        chk("ab_b_src2", 64'(issue_src2), 64'h22);
        broadcast(4'd9, 32'hDEAD_BEEF);
        chk("ab_gap_valid", 64'(issue_valid), 64'h0);
        chk("ab_gap_occ", 64'(occupancy), 64'd1);
        @(negedge clk);
        chk("ab_a_valid", 64'(issue_valid), 64'h1);
        chk("ab_a_tag", 64'(issue_tag), 64'd0);
        chk("ab_a_src1", 64'(issue_src1), 64'hDEAD_BEEF);
        chk("ab_a_src2", 64'(issue_src2), 64'h2);
        chk("ab_a_occ", 64'(occupancy), 64'd0);
        @(negedge clk);
        chk("ab_end_valid", 64'(issue_valid), 64'h0);

        // Same-cycle CDB bypass at dispatch.
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h55;
        dispatch(3'd3, 1'b0, 32'hFFFF, 4'd7, 1'b1, 32'h66, 4'd0);
        cdb_valid = 1'b0;
        chk("byp_occ", 64'(occupancy), 64'd1);
        @(negedge clk);
        chk("byp_valid", 64'(issue_valid), 64'h1);
        chk("byp_src1", 64'(issue_src1), 64'h55);
        chk("byp_src2", 64'(issue_src2), 64'h66);
        chk("byp_op", 64'(issue_op), 64'd3);
        @(negedge clk);
        chk("byp_end_valid", 64'(issue_valid), 64'h0);

        // Age order 2,0,3,1 built by selective wakeup and refill.
        for (int k = 0; k < 4; k++) begin
            chk("age_fill_tag", 64'(disp_tag), 64'(k));
            dispatch(3'(k), 1'b0, 32'h0, 4'(10 + k), 1'b1, 32'(k), 4'd0);
        end
        wake_refill(4'd12, 2);
        wake_refill(4'd10, 0);
        wake_refill(4'd13, 3);
        wake_refill(4'd11, 1);
        broadcast(4'd15, 32'h77);
        chk("age_wake_no_issue", 64'(issue_valid), 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("age_valid", 64'(issue_valid), 64'h1);
            chk("age_order_tag", 64'(issue_tag), 64'(ord[k]));
            chk("age_src1", 64'(issue_src1), 64'h77);
            chk("age_src2", 64'(issue_src2), 64'h20 + 64'(ord[k]));
        end
        @(negedge clk);
        chk("age_end_valid", 64'(issue_valid), 64'h0);
        chk("age_end_occ", 64'(occupancy), 64'd0);

        // Backpressure: issue register holds while issue_ready is low.
        issue_ready = 1'b0;
        dispatch(3'd5, 1'b1, 32'hA0, 4'd0, 1'b1, 32'hB0, 4'd0);
        chk("bp_disp_tag_y", 64'(disp_tag), 64'd1);
        dispatch(3'd6, 1'b1, 32'hC0, 4'd0, 1'b1, 32'hD0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 64'(issue_valid), 64'h1);
            chk("bp_hold_tag", 64'(issue_tag), 64'd0);
            chk("bp_hold_op", 64'(issue_op), 64'd5);
            chk("bp_hold_src1", 64'(issue_src1), 64'hA0);
            chk("bp_hold_src2", 64'(issue_src2), 64'hB0);
            chk("bp_hold_occ", 64'(occupancy), 64'd1);
            @(negedge clk);
        end
        issue_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_tag", 64'(issue_tag), 64'd1);
        chk("bp_next_src1", 64'(issue_src1), 64'hC0);
        chk("bp_next_occ", 64'(occupancy), 64'd0);
        @(negedge clk);
        chk("bp_end_valid", 64'(issue_valid), 64'h0);

        // Flush with three busy entries and a held issue register.
        issue_ready = 1'b0;
        chk("fl_tag0", 64'(disp_tag), 64'd0);
        dispatch(3'd1, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0);
        chk("fl_tag1", 64'(disp_tag), 64'd1);
        dispatch(3'd2, 1'b1, 32'h2, 4'd0, 1'b1, 32'h2, 4'd0);
        chk("fl_tag_reuse0", 64'(disp_tag), 64'd0);
        dispatch(3'd3, 1'b1, 32'h3, 4'd0, 1'b1, 32'h3, 4'd0);
        chk("fl_tag2", 64'(disp_tag), 64'd2);
        dispatch(3'd4, 1'b1, 32'h4, 4'd0, 1'b1, 32'h4, 4'd0);
        chk("fl_pre_occ", 64'(occupancy), 64'd3);
        chk("fl_pre_valid", 64'(issue_valid), 64'h1);
        flush = 1'b1;
        #1;
        chk("fl_disp_ready_low", 64'(disp_ready), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_issue_valid", 64'(issue_valid), 64'h0);
        chk("fl_disp_tag", 64'(disp_tag), 64'd0);
        chk("fl_disp_ready", 64'(disp_ready), 64'h1);

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        dispatch(3'd5, 1'b1, 32'h9, 4'd0, 1'b1, 32'h8, 4'd0);
        dispatch(3'd6, 1'b1, 32'h7, 4'd0, 1'b1, 32'h6, 4'd0);
        chk("ar_pre_valid", 64'(issue_valid), 64'h1);
        chk("ar_pre_occ", 64'(occupancy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_issue_valid", 64'(issue_valid), 64'h0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_issue_op", 64'(issue_op), 64'h0);
        chk("ar_issue_src1", 64'(issue_src1), 64'h0);
        chk("ar_issue_tag", 64'(issue_tag), 64'h0);
        chk("ar_disp_tag", 64'(disp_tag), 64'd0);
        chk("ar_disp_ready", 64'(disp_ready), 64'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ar_post_valid", 64'(issue_valid), 64'h0);
        chk("ar_post_occ", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
